// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the nic8 step controller.
package step_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_HALT  = 2'd1,
    OP_STEP  = 2'd2,
    OP_RUN_N = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_COUNT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_CMD   = 2'd1,
    CAUSE_COUNT = 2'd2,
    CAUSE_BREAK = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/step_ctrl_step_counter.sv
// Remaining-step down-counter for bounded (COUNT) execution.
module step_counter
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  logic [CNT_W-1:0] count_q;

  // clear beats load beats decrement; never wraps below zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == CNT_W'(1));

endmodule

// File: rtl/step_ctrl.sv
// nic8 CPU clock-enable controller: run / halt / step / run-N commands.
// Optional breakpoint compare enabled by defining STEP_CTRL_BREAKPOINT_EN.
//
// state     | meaning
// ST_HALTED | cpu_en low, waiting for a command
// ST_RUN    | free-running until HALT (or breakpoint)
// ST_COUNT  | bounded run, halts when steps_left reaches 0
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [7:0]       pc,
`ifdef STEP_CTRL_BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [7:0]       bp_addr,
`endif
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] steps_left,
  output logic [CNT_W-1:0] ticks,
  output logic             cmd_err
);

  state_e           state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] ticks_q;
  logic             cmd_err_q, cmd_err_d;
  logic             accept;
  cmd_op_e          op;
  logic             bp_hit;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val;

  assign cmd_ready = reset_n;
  assign accept    = cmd_valid;
  assign op        = cmd_op_e'(cmd_op);

`ifdef STEP_CTRL_BREAKPOINT_EN
  logic skip_bp_q;

  // lets a resume from the breakpoint address execute that instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_bp_q <= 1'b0;
    end else if ((state_q == ST_HALTED) && (state_d != ST_HALTED)) begin
      skip_bp_q <= 1'b1;
    end else if (cpu_en) begin
      skip_bp_q <= 1'b0;
    end
  end

  assign bp_hit = bp_valid && (pc == bp_addr) && (state_q != ST_HALTED) && !skip_bp_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  assign cpu_en = (state_q != ST_HALTED) && !bp_hit;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cmd_err_d    = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = cmd_arg;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_HALTED: begin
        if (accept) begin
          case (op)
            OP_RUN: state_d = ST_RUN;
            OP_STEP: begin
              state_d      = ST_COUNT;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(1);
            end
            OP_RUN_N: begin
              if (cmd_arg != '0) begin
                state_d  = ST_COUNT;
                cnt_load = 1'b1;
              end else begin
                cause_d = CAUSE_COUNT;
              end
            end
            OP_HALT: cause_d = CAUSE_CMD;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (accept && (op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end else begin
          cmd_err_d = accept;
          if (bp_hit) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_BREAK;
          end
        end
      end

      ST_COUNT: begin
        // a breakpoint cycle has cpu_en low, so it never consumes a step
        cnt_dec = cpu_en;
        if (accept && (op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end else begin
          cmd_err_d = accept;
          if (bp_hit) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_BREAK;
          end else if (cnt_is_one) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_COUNT;
          end
        end
      end

      default: state_d = ST_HALTED;
    endcase

    if (state_d != ST_COUNT) begin
      cnt_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HALTED;
      cause_q   <= CAUSE_RESET;
      cmd_err_q <= 1'b0;
      ticks_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cmd_err_q <= cmd_err_d;
      if (cpu_en) begin
        ticks_q <= ticks_q + CNT_W'(1);
      end
    end
  end

  step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (steps_left),
    .is_one   (cnt_is_one)
  );

  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign ticks      = ticks_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Drives the nic8 CPU clock-enable; the control-side counterpart of the passive trace monitor.
- Accepts run / halt / single-step / run-N commands over a valid/ready port.
- Gates CPU advancement with `cpu_en` and counts executed ticks.
- Reports halt state and halt cause, so benches and a future front panel can step the machine deterministically instead of relying on a simulation step limit.

Parameters:
- `CNT_W`, 16: width of step argument, `steps_left` and `ticks` counters.

Ports:
- `clk`  in  1  system clock; CPU registers advance on posedge `clk` when `cpu_en`=1.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid`&&`cmd_ready`.
- `cmd_op`  in  2  0=RUN, 1=HALT, 2=STEP, 3=RUN_N.
- `cmd_arg`  in  `CNT_W`  step count for RUN_N; ignored otherwise.
- `pc`  in  8  current CPU program counter.
- `cpu_en`  out  1  CPU clock enable; one CPU tick per cycle it is high.
- `halted`  out  1  state==HALTED.
- `halt_cause`  out  2  0=RESET, 1=CMD, 2=COUNT, 3=BREAK.
- `steps_left`  out  `CNT_W`  remaining steps in COUNT mode, else 0.
- `ticks`  out  `CNT_W`  number of `cpu_en` cycles since reset; wraps modulo 2^`CNT_W`.
- `cmd_err`  out  1  one-cycle pulse when an accepted command is ignored.

Behaviour:
- Reset (async, any time, mid-run included): state=HALTED, `cpu_en`=0, `halt_cause`=RESET, `steps_left`=0, `ticks`=0, `cmd_err`=0, `skip_bp`=0.
- `cmd_ready` is tied to 1 outside reset; commands are never back-pressured.
- States: HALTED, RUN (free-running), COUNT (bounded).
- `cpu_en` is combinational: (state==RUN || state==COUNT) && !`bp_hit`. `bp_hit` is 0 when the feature is off.
- Transitions from HALTED:
  - RUN -> RUN.
  - STEP -> COUNT with `steps_left`=1.
  - RUN_N with arg>0 -> COUNT with `steps_left`=arg.
  - RUN_N with arg=0 -> stay HALTED, `halt_cause`=COUNT, no `cpu_en`.
  - HALT -> stay HALTED, `halt_cause`=CMD.
- The first `cpu_en` is asserted in the cycle after the command is accepted.
- RUN/COUNT: HALT -> HALTED next cycle, `halt_cause`=CMD. Any other op -> `cmd_err` pulse, no state change.
- COUNT: each `cpu_en` cycle decrements `steps_left`. The decrement from 1 to 0 moves to HALTED next cycle with `halt_cause`=COUNT, giving exactly N `cpu_en` pulses for RUN_N(N).
- Simultaneous HALT command and final count step:
  - the final step still executes (`cpu_en`=1 that cycle);
  - `halt_cause`=CMD (command wins the cause code).
- `ticks` increments on every cycle with `cpu_en`=1.
- `halt_cause` holds until the next transition into HALTED or reset.
- `steps_left` is forced to 0 on entry to HALTED or RUN.

Optional Feature:
- Macro `STEP_CTRL_BREAKPOINT_EN`.
- With it defined, add ports `bp_valid` (in, 1) and `bp_addr` (in, 8).
- `bp_hit` = `bp_valid` && `pc`==`bp_addr` && state!=HALTED && !`skip_bp`.
- On `bp_hit`: `cpu_en`=0 that cycle, and next state HALTED with `halt_cause`=BREAK. A breakpoint does not consume a COUNT step.
- `skip_bp` is set when leaving HALTED and cleared after the first `cpu_en` cycle, so a resume from a breakpoint address executes that instruction.
- Without the macro: no extra ports, `bp_hit`=0, and cause BREAK is never produced.

Decomposition:
- Package `step_ctrl_pkg` holds:
  - typedef for `cmd_op` enum (RUN, HALT, STEP, RUN_N);
  - state enum (HALTED, RUN, COUNT);
  - `halt_cause` enum (RESET, CMD, COUNT, BREAK);
  - default `CNT_W` constant.
- One sub-module `step_counter` (load / decrement / is-one flag, `CNT_W` wide). The FSM and breakpoint compare stay in `step_ctrl`.

Test Plan:
- Reset then idle 10 cycles -> `halted`=1, `cause`=0, `cpu_en`=0, `ticks`=0.
- RUN_N arg=5 -> exactly 5 consecutive `cpu_en` pulses starting the cycle after accept; `ticks`=5, `halted`=1, `cause`=2.
- RUN, then HALT 20 cycles later -> `ticks`=20, `cause`=1. STEP issued while running -> `cmd_err` pulse, no state change.
- HALT in the same cycle as the last step of RUN_N arg=3 -> `ticks`=3, `cause`=1. RUN_N arg=0 -> no `cpu_en`, `cause`=2.
- With `STEP_CTRL_BREAKPOINT_EN`, `bp_addr`=0x07, bench pc increments per `cpu_en` from 0: after RUN, halts with `pc`=0x07, `ticks`=7, `cause`=3. A following STEP -> 1 pulse, `pc`=0x08.
- Assert `reset_n` low mid-RUN -> `cpu_en` drops immediately (async); all outputs take their reset values.
